// File: rtl/seq_match_ctrl_pkg.sv
// Shared types and defaults for the serial pattern-match run controller.
package seq_match_ctrl_pkg;

   localparam int unsigned MAXLEN_DEF = 8;
   localparam int unsigned CNT_W_DEF  = 4;
   localparam int unsigned WIN_W_DEF  = 8;
   localparam int unsigned LEN_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Map a requested length onto the legal range 1..maxlen.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                  input int unsigned     maxlen);
      if (len == '0) return LEN_W'(1);
      if (32'(len) > maxlen) return LEN_W'(maxlen);
      return len;
   endfunction

endpackage

// File: rtl/seq_match_ctrl_shift.sv
// Shift register, fill counter and masked compare against the latched pattern.
module seq_shift_match
   import seq_match_ctrl_pkg::*;
#(
   parameter int unsigned MAXLEN = MAXLEN_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              shift_en,
   input  logic              clr,
   input  logic              x,
   input  logic [LEN_W-1:0]  len,
   input  logic [MAXLEN-1:0] pattern,
   output logic              hit
);

   logic [MAXLEN-1:0] sr;
   logic [LEN_W-1:0]  bits_seen;
   logic [MAXLEN-1:0] mask;

   always_comb begin
      mask = '0;
      for (int i = 0; i < int'(MAXLEN); i++) begin
         mask[i] = (i < int'(len));
      end
   end

   assign hit = (bits_seen >= len) && (((sr ^ pattern) & mask) == '0);

   // Clear is applied before the shift, so a bit arriving with clr is the first fresh bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr        <= '0;
         bits_seen <= '0;
      end else if (clr) begin
         sr        <= shift_en ? {{(MAXLEN-1){1'b0}}, x} : '0;
         bits_seen <= shift_en ? LEN_W'(1) : '0;
      end else if (shift_en) begin
         sr        <= {sr[MAXLEN-2:0], x};
         bits_seen <= (bits_seen == LEN_W'(MAXLEN)) ? bits_seen : bits_seen + LEN_W'(1);
      end
   end

endmodule

// File: rtl/seq_match_ctrl.sv
// Run controller: latches config, scans qualified serial bits, counts matches, ends runs.
module seq_match_ctrl
   import seq_match_ctrl_pkg::*;
#(
   parameter int unsigned MAXLEN = MAXLEN_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF,
   parameter int unsigned WIN_W  = WIN_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [MAXLEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              cfg_overlap,
   input  logic [CNT_W-1:0]  cfg_target,
   input  logic [WIN_W-1:0]  cfg_window,
   input  logic              start,
   input  logic              abort,
   input  logic              x,
   input  logic              x_valid,
   output logic              busy,
   output logic              match,
   output logic [CNT_W-1:0]  count,
   output logic              done,
   output logic              hit_target
);

   state_t            state;
   logic [LEN_W-1:0]  len_q;
   logic [MAXLEN-1:0] pat_q;
   logic              ovl_q;
   logic [CNT_W-1:0]  tgt_q;
   logic [WIN_W-1:0]  win_q;
   logic [WIN_W-1:0]  win_cnt;
   logic              acc_q;

   logic              hit_c;
   logic              run_c;
   logic              launch_c;
   logic              match_c;
   logic [CNT_W-1:0]  cnt_inc_c;
   logic              stop_tgt_c;
   logic              stop_win_c;
   logic              stop_c;
   logic              shift_en_c;
   logic              clr_c;

   // acc_q marks that the shift register holds a freshly accepted bit to be judged this cycle.
   assign run_c      = (state == ST_RUN) && !abort;
   assign launch_c   = (state != ST_RUN) && (state != ST_DONE) && start && !abort;
   assign match_c    = run_c && acc_q && hit_c;
   assign cnt_inc_c  = (count == '1) ? count : count + CNT_W'(1);
   assign stop_tgt_c = match_c && (tgt_q != '0) && (cnt_inc_c == tgt_q);
   assign stop_win_c = run_c && acc_q && (win_q != '0) && (win_cnt == win_q);
   assign stop_c     = stop_tgt_c || stop_win_c;
   assign shift_en_c = run_c && x_valid && !stop_c;
   assign clr_c      = launch_c || (match_c && !ovl_q);

   seq_shift_match #(
      .MAXLEN (MAXLEN)
   ) u_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (shift_en_c),
      .clr      (clr_c),
      .x        (x),
      .len      (len_q),
      .pattern  (pat_q),
      .hit      (hit_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         len_q      <= LEN_W'(1);
         pat_q      <= '0;
         ovl_q      <= 1'b0;
         tgt_q      <= '0;
         win_q      <= '0;
         win_cnt    <= '0;
         acc_q      <= 1'b0;
         busy       <= 1'b0;
         match      <= 1'b0;
         count      <= '0;
         done       <= 1'b0;
         hit_target <= 1'b0;
      end else begin
         match <= 1'b0;
         done  <= 1'b0;
         case (state)
            ST_RUN: begin
               if (abort) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  acc_q <= 1'b0;
               end else begin
                  if (match_c) begin
                     match <= 1'b1;
                     count <= cnt_inc_c;
                  end
                  // A stopping cycle drops any bit presented alongside it.
                  if (stop_c) begin
                     state      <= ST_DONE;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     hit_target <= stop_tgt_c;
                     acc_q      <= 1'b0;
                  end else begin
                     acc_q <= x_valid;
                     if (x_valid) win_cnt <= win_cnt + WIN_W'(1);
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               if (launch_c) begin
                  state      <= ST_RUN;
                  busy       <= 1'b1;
                  len_q      <= clamp_len(cfg_len, MAXLEN);
                  pat_q      <= cfg_pattern;
                  ovl_q      <= cfg_overlap;
                  tgt_q      <= cfg_target;
                  win_q      <= cfg_window;
                  count      <= '0;
                  win_cnt    <= '0;
                  acc_q      <= 1'b0;
                  hit_target <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule
